// File: rtl/pipeline_wb_reg_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
// Shared encodings for the writeback stage register.
//   memtoreg_e : writeback data source select
//   regdst_e   : destination register select
//   ldsize_e   : load access size
//   *Default   : default special-register indices and PC offset
// ----------------------------------------------------------------------------
package pipeline_pkg;

    // Writeback data source.
    typedef enum logic [1:0] {
        MemToRegAlu   = 2'd0,  // ALU result
        MemToRegLoad  = 2'd1,  // aligned and extended load data
        MemToRegPc    = 2'd2,  // zero-extended PC
        MemToRegPcOff = 2'd3   // zero-extended PC minus fixed offset
    } memtoreg_e;

    // Destination register select.
    typedef enum logic [1:0] {
        RegDstRt   = 2'd0,  // decoded destination
        RegDstRd   = 2'd1,  // decoded destination
        RegDstLink = 2'd2,  // link register
        RegDstXcpt = 2'd3   // exception return register
    } regdst_e;

    // Load access size; the fourth code behaves as a full word.
    typedef enum logic [1:0] {
        LdSizeWord    = 2'd0,
        LdSizeHalf    = 2'd1,
        LdSizeByte    = 2'd2,
        LdSizeWordAlt = 2'd3
    } ldsize_e;

    localparam int unsigned LinkRegDefault  = 31;
    localparam int unsigned XcptRegDefault  = 26;
    localparam int unsigned PcOffsetDefault = 4;

endpackage

// File: rtl/pipeline_wb_reg_if.sv
// ----------------------------------------------------------------------------
// pipeline_wb_reg_if
// Bundles the MEM-to-WB handshake and the writeback outputs.
//   master : MEM-stage side; drives in_*, stall, flush; observes wb_*, retire_cnt
//   slave  : writeback stage register; the reverse
// Parameters must match those of the pipeline_wb_reg instance it connects to.
// ----------------------------------------------------------------------------
interface pipeline_wb_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 31,
    parameter int unsigned ADDR_W = 5
);

    // MEM stage to WB stage
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [1:0]        in_regdst;
    logic [1:0]        in_memtoreg;
    logic              in_regwrite;
    logic [ADDR_W-1:0] in_wrreg;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_mem;
    logic [PC_W-1:0]   in_pc;
    logic [1:0]        in_ldsize;
    logic              in_ldsign;
    logic [1:0]        in_byteoff;

    // WB stage to register file / performance counters
    logic              wb_valid;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       retire_cnt;

    modport master (
        output in_valid, stall, flush, in_regdst, in_memtoreg, in_regwrite, in_wrreg,
               in_alu, in_mem, in_pc, in_ldsize, in_ldsign, in_byteoff,
        input  wb_valid, wb_we, wb_dest, wb_data, retire_cnt
    );

    modport slave (
        input  in_valid, stall, flush, in_regdst, in_memtoreg, in_regwrite, in_wrreg,
               in_alu, in_mem, in_pc, in_ldsize, in_ldsign, in_byteoff,
        output wb_valid, wb_we, wb_dest, wb_data, retire_cnt
    );

endinterface

// File: rtl/pipeline_wb_reg_load_align.sv
// ----------------------------------------------------------------------------
// wb_load_align
// Little-endian load lane selection and sign/zero extension.
//   mem     in  DATA_W  raw memory word (only bits [31:0] carry load data)
//   ldsize  in  2       access size (word / half / byte / word)
//   ldsign  in  1       1 sign-extend, 0 zero-extend
//   byteoff in  2       address bits [1:0]
//   data    out DATA_W  aligned, extended load result
// ----------------------------------------------------------------------------
module wb_load_align
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] mem,
    input  ldsize_e           ldsize,
    input  logic              ldsign,
    input  logic [1:0]        byteoff,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem[7:0];
        unique case (byteoff)
            2'd0: byte_sel = mem[7:0];
            2'd1: byte_sel = mem[15:8];
            2'd2: byte_sel = mem[23:16];
            2'd3: byte_sel = mem[31:24];
        endcase
    end

    // Halfwords are assumed aligned: byteoff[0] plays no part.
    assign half_sel = byteoff[1] ? mem[31:16] : mem[15:0];

    always_comb begin
        data = '0;
        unique case (ldsize)
            LdSizeHalf: begin
                data        = {DATA_W{ldsign & half_sel[15]}};
                data[15:0]  = half_sel;
            end
            LdSizeByte: begin
                data        = {DATA_W{ldsign & byte_sel[7]}};
                data[7:0]   = byte_sel;
            end
            LdSizeWord, LdSizeWordAlt: begin
                // Bits above the 32-bit memory word stay zero on wide datapaths.
                data        = '0;
                data[31:0]  = mem[31:0];
            end
        endcase
    end

endmodule

// File: rtl/pipeline_wb_reg.sv
// ----------------------------------------------------------------------------
// pipeline_wb_reg
// MEM/WB stage register with writeback decode and a retired-instruction counter.
//   clk   in  1   rising-edge clock
//   reset in  1   asynchronous active-low reset
//   bus   slave modport of pipeline_wb_reg_if:
//         in_*, stall, flush           captured fields and pipeline control
//         wb_valid, wb_we, wb_dest,    writeback outputs, decoded combinationally
//         wb_data                      from the stage register
//         retire_cnt                   32-bit wrapping retire counter
// An entry retires when it leaves the stage unflushed (valid, no stall, no flush).
// ----------------------------------------------------------------------------
module pipeline_wb_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PC_W      = 31,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned LINK_REG  = LinkRegDefault,
    parameter int unsigned XCPT_REG  = XcptRegDefault,
    parameter int unsigned PC_OFFSET = PcOffsetDefault
) (
    input  logic             clk,
    input  logic             reset,
    pipeline_wb_reg_if.slave bus
);

    if (PC_W >= DATA_W || DATA_W < 32) begin : gen_param_check
        $error("pipeline_wb_reg: need PC_W < DATA_W and DATA_W >= 32");
    end

    // ------------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------------
    logic              valid_q, valid_d;
    regdst_e           regdst_q;
    memtoreg_e         memtoreg_q;
    logic              regwrite_q;
    logic [ADDR_W-1:0] wrreg_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] mem_q;
    logic [PC_W-1:0]   pc_q;
    ldsize_e           ldsize_q;
    logic              ldsign_q;
    logic [1:0]        byteoff_q;
    logic [31:0]       retire_q, retire_d;

    logic capture;
    logic retire;

    // Flush wins over stall; a stalled stage keeps every field.
    assign capture = !bus.flush && !bus.stall;
    assign retire  = valid_q && capture;

    always_comb begin
        valid_d = valid_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            valid_d = bus.in_valid;
        end
    end

    always_comb begin
        retire_d = retire_q;
        if (retire) begin
            retire_d = retire_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            regdst_q   <= RegDstRt;
            memtoreg_q <= MemToRegAlu;
            regwrite_q <= 1'b0;
            wrreg_q    <= '0;
            alu_q      <= '0;
            mem_q      <= '0;
            pc_q       <= '0;
            ldsize_q   <= LdSizeWord;
            ldsign_q   <= 1'b0;
            byteoff_q  <= '0;
            retire_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            retire_q <= retire_d;
            if (capture) begin
                regdst_q   <= regdst_e'(bus.in_regdst);
                memtoreg_q <= memtoreg_e'(bus.in_memtoreg);
                regwrite_q <= bus.in_regwrite;
                wrreg_q    <= bus.in_wrreg;
                alu_q      <= bus.in_alu;
                mem_q      <= bus.in_mem;
                pc_q       <= bus.in_pc;
                ldsize_q   <= ldsize_e'(bus.in_ldsize);
                ldsign_q   <= bus.in_ldsign;
                byteoff_q  <= bus.in_byteoff;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Writeback decode
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] pc_ext;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_dest;
    logic              wb_we;

    wb_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .mem     (mem_q),
        .ldsize  (ldsize_q),
        .ldsign  (ldsign_q),
        .byteoff (byteoff_q),
        .data    (load_data)
    );

    always_comb begin
        pc_ext            = '0;
        pc_ext[PC_W-1:0]  = pc_q;
    end

    always_comb begin
        wb_data = alu_q;
        unique case (memtoreg_q)
            MemToRegAlu:   wb_data = alu_q;
            MemToRegLoad:  wb_data = load_data;
            MemToRegPc:    wb_data = pc_ext;
            // Wraps modulo 2^DATA_W for PCs below the offset.
            MemToRegPcOff: wb_data = pc_ext - DATA_W'(PC_OFFSET);
        endcase
    end

    always_comb begin
        wb_dest = wrreg_q;
        unique case (regdst_q)
            RegDstLink:          wb_dest = ADDR_W'(LINK_REG);
            RegDstXcpt:          wb_dest = ADDR_W'(XCPT_REG);
            RegDstRt, RegDstRd:  wb_dest = wrreg_q;
        endcase
    end

    // Register zero is hardwired, so writes to it are suppressed.
    assign wb_we = valid_q && regwrite_q && (wb_dest != '0);

    assign bus.wb_valid   = valid_q;
    assign bus.wb_we      = wb_we;
    assign bus.wb_dest    = wb_dest;
    assign bus.wb_data    = wb_data;
    assign bus.retire_cnt = retire_q;

endmodule

// File: doc/pipeline_wb_reg.md
PIPELINE_WB_REG -- requirements
Module: pipeline_wb_reg

Interface
REQ-001 Parameter DATA_W, 32, writeback data width.
REQ-002 Parameter PC_W, 31, incoming PC width; SHALL satisfy PC_W < DATA_W.
REQ-003 Parameter ADDR_W, 5, register-address width.
REQ-004 Parameter LINK_REG, 31, destination for RegDst=2.
REQ-005 Parameter XCPT_REG, 26, destination for RegDst=3.
REQ-006 Parameter PC_OFFSET, 4, subtrahend for MemtoReg=3.
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 reset  in  1  asynchronous active-low reset.
REQ-010 in_valid  in  1  MEM stage presents an instruction.
REQ-011 stall  in  1  hold stage register contents.
REQ-012 flush  in  1  invalidate stage register.
REQ-013 in_regdst, in_memtoreg  in  2 each  destination select and writeback source select.
REQ-014 in_regwrite  in  1  instruction writes the register file.
REQ-015 in_wrreg  in  ADDR_W  decoded destination.
REQ-016 in_alu, in_mem  in  DATA_W each  ALU result and raw memory word.
REQ-017 in_pc  in  PC_W  instruction PC.
REQ-018 in_ldsize  in  2  0 word, 1 half, 2 byte, 3 treated as word.
REQ-019 in_ldsign  in  1  1 sign-extend, 0 zero-extend.
REQ-020 in_byteoff  in  2  address bits [1:0].
REQ-021 wb_valid  out  1  stage register holds a live instruction.
REQ-022 wb_we  out  1  register-file write enable.
REQ-023 wb_dest  out  ADDR_W  register-file write address.
REQ-024 wb_data  out  DATA_W  register-file write data.
REQ-025 retire_cnt  out  32  retired-instruction counter.

Function
REQ-026 On each rising edge with flush=1, the stage SHALL clear wb_valid; flush has priority over stall.
REQ-027 With flush=0, stall=0, the stage SHALL capture all in_* fields and set wb_valid=in_valid.
REQ-028 With flush=0, stall=1, the stage SHALL hold all captured fields unchanged.
REQ-029 Outputs SHALL be decoded combinationally from the stage register: latency exactly one cycle from capture.
REQ-030 wb_data SHALL be: memtoreg 0 -> alu; 1 -> aligned load; 2 -> zero-extended pc; 3 -> zero-extended pc minus PC_OFFSET, modulo 2^DATA_W.
REQ-031 wb_dest SHALL be: regdst 2 -> LINK_REG; 3 -> XCPT_REG; else wrreg.
REQ-032 wb_we SHALL equal wb_valid AND regwrite AND (wb_dest != 0).
REQ-033 Aligned load, little-endian: byte = mem[8*off+7 : 8*off]; half = mem[15:0] if off[1]=0, else mem[31:16]; off[0] is ignored for half; word = mem unchanged.
REQ-034 Byte and half results SHALL be extended to DATA_W per ldsign; bits above 31 SHALL be zero-filled for word loads when DATA_W > 32.
REQ-035 retire_cnt SHALL increment by 1 on each edge where wb_valid=1, stall=0, and flush=0; it SHALL wrap from 2^32-1 to 0.
REQ-036 A flushed or stalled-held entry SHALL NOT be counted until it departs unflushed.

Reset
REQ-037 While reset=0: wb_valid=0, wb_we=0, retire_cnt=0, and all captured fields=0 (wb_dest=0, wb_data=0), regardless of clk.
REQ-038 Reset asserted mid-stall SHALL discard the held entry without counting it.
REQ-039 Capture resumes on the first rising edge after reset deasserts.

Structure
REQ-040 Package pipeline_pkg SHALL hold the MemtoReg, RegDst and ldsize encodings and the default LINK_REG and XCPT_REG constants.
REQ-041 Load byte/half selection and extension SHALL be a sub-module named wb_load_align; all other logic lives in pipeline_wb_reg.

Verification
REQ-042 in_valid=1, memtoreg=0, regwrite=1, wrreg=5, alu=0x1234 -> next cycle: wb_we=1, wb_dest=5, wb_data=0x00001234; retire_cnt increments on the following unstalled edge.
REQ-043 memtoreg=1, ldsize=2, ldsign=1, off=3, mem=0x80FF_FF7F -> wb_data=0xFFFFFF80; same stimulus with ldsign=0 -> 0x00000080; ldsize=1, off=2, ldsign=1 -> 0xFFFF80FF.
REQ-044 memtoreg=3, regdst=2, pc=0x0000_0000 -> wb_data=0xFFFFFFFC, wb_dest=31; memtoreg=2, regdst=3, pc=0x4000_0010 -> wb_data=0x40000010, wb_dest=26.
REQ-045 stall=1 for 3 cycles with new inputs applied -> outputs unchanged and retire_cnt static; then flush=1 and stall=1 together -> wb_valid=0, and the held entry is never counted.
REQ-046 regwrite=1, wrreg=0 -> wb_we=0; retire_cnt preloaded to 0xFFFFFFFF plus one retire -> 0; reset=0 asserted mid-operation -> all outputs 0 immediately.
